// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter_if
//  Description : Bundles the core writeback, extension-unit result and
//                register-file write-port signals around wb_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if;
  // Core writeback path and hazard sources
  logic        core_we;
  logic [4:0]  core_rd;
  logic [31:0] core_data;
  logic [4:0]  core_rs1;
  logic [4:0]  core_rs2;
  logic        core_stall;
  // Extension unit result handshake
  logic        ext_valid;
  logic [4:0]  ext_rd;
  logic [31:0] ext_data;
  logic        ext_ready;
  // Register-file write port
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  // Environment side: drives the core/extension sources, observes the port
  modport master (
    output core_we, core_rd, core_data, core_rs1, core_rs2,
    output ext_valid, ext_rd, ext_data,
    input  ext_ready, core_stall, rf_we, rf_rd, rf_data
  );

  // Arbiter side
  modport slave (
    input  core_we, core_rd, core_data, core_rs1, core_rs2,
    input  ext_valid, ext_rd, ext_data,
    output ext_ready, core_stall, rf_we, rf_rd, rf_data
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Shares the single register-file write port between the core
//                writeback path and a buffered multi-cycle extension unit.
//                Core has priority unless stalled by a hazard against a
//                buffered result or by starvation of the FIFO head.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  wb_port_arbiter_if.slave bus
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

  // FIFO storage; r_vld marks occupied slots so the hazard check can scan
  // every entry without decoding the pointer window.
  logic [4:0]          r_rd_mem   [DEPTH];
  logic [31:0]         r_data_mem [DEPTH];
  logic [DEPTH-1:0]    r_vld;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_WAIT_W-1:0] r_wait;

  logic             w_full;
  logic             w_empty;
  logic [DEPTH-1:0] w_hit_vec;
  logic             w_hit;
  logic             w_starve;
  logic             w_stall;
  logic             w_ext_ready;
  logic             w_core_grant;
  logic             w_pop;
  logic             w_push;

  assign w_full   = (r_count == c_CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_starve = (r_wait == c_WAIT_W'(MAX_WAIT));

  // Per-entry hazard: a stored result still pending for a register the core
  // reads (RAW) or is about to overwrite (WAW).
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign w_hit_vec[i] = r_vld[i] && (r_rd_mem[i] != 5'd0) &&
                          ((r_rd_mem[i] == bus.core_rs1) ||
                           (r_rd_mem[i] == bus.core_rs2) ||
                           (bus.core_we && (r_rd_mem[i] == bus.core_rd)));
  end

  assign w_hit        = |w_hit_vec;
  assign w_stall      = rst_n && (w_hit || w_starve);
  assign w_ext_ready  = rst_n && !w_full;
  // Writes to x0 never take the port, so the FIFO head can use it instead.
  assign w_core_grant = rst_n && !w_stall && bus.core_we && (bus.core_rd != 5'd0);
  assign w_pop        = rst_n && !w_core_grant && !w_empty;
  // Results for x0 complete the handshake but are dropped.
  assign w_push       = bus.ext_valid && w_ext_ready && (bus.ext_rd != 5'd0);

  // Write-port mux and handshake outputs
  always_comb begin
    bus.ext_ready  = w_ext_ready;
    bus.core_stall = w_stall;
    bus.rf_we      = 1'b0;
    bus.rf_rd      = 5'd0;
    bus.rf_data    = 32'd0;
    if (w_core_grant) begin
      bus.rf_we   = 1'b1;
      bus.rf_rd   = bus.core_rd;
      bus.rf_data = bus.core_data;
    end else if (w_pop) begin
      bus.rf_we   = 1'b1;
      bus.rf_rd   = r_rd_mem[r_rd_ptr];
      bus.rf_data = r_data_mem[r_rd_ptr];
    end
  end

  // FIFO pointers, occupancy and storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd_mem[i]   <= 5'd0;
        r_data_mem[i] <= 32'd0;
      end
    end else begin
      // Push and pop never target the same slot: a pop needs a non-empty
      // FIFO and a push a non-full one, so the pointers differ.
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_vld[r_wr_ptr]      <= 1'b1;
        r_rd_mem[r_wr_ptr]   <= bus.ext_rd;
        r_data_mem[r_wr_ptr] <= bus.ext_data;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Cycles the FIFO head has been denied the port, saturating at MAX_WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (w_pop || w_empty) begin
      r_wait <= '0;
    end else if (!w_starve) begin
      r_wait <= r_wait + c_WAIT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_port_arbiter
//  Description : Directed bench for wb_port_arbiter; expected register-file
//                writes are queued by the stimulus and matched by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [36:0] exp_q [$];
  logic [36:0] mon_e;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.core_we   = 1'b0;
    bus.core_rd   = 5'd0;
    bus.core_data = 32'd0;
    bus.core_rs1  = 5'd0;
    bus.core_rs2  = 5'd0;
    bus.ext_valid = 1'b0;
    bus.ext_rd    = 5'd0;
    bus.ext_data  = 32'd0;
  endtask

  task automatic ext(input logic [4:0] rd, input logic [31:0] d);
    bus.ext_valid = 1'b1;
    bus.ext_rd    = rd;
    bus.ext_data  = d;
  endtask

  task automatic core(input logic [4:0] rd, input logic [31:0] d);
    bus.core_we   = 1'b1;
    bus.core_rd   = rd;
    bus.core_data = d;
  endtask

  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  // Monitor: every register-file write must match the head of the queue
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rf_we_in_reset", 32'(bus.rf_we), 32'd0);
    end else if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h required no write at %0t",
                 bus.rf_rd, bus.rf_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_rd", 32'(bus.rf_rd), 32'(mon_e[36:32]));
        chk("wb_data", bus.rf_data, mon_e[31:0]);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  logic [4:0] wrap_seq [10];

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    core(5'd3, 32'h33);
    #3;
    chk("reset_rf_we", 32'(bus.rf_we), 32'd0);
    chk("reset_rf_rd", 32'(bus.rf_rd), 32'd0);
    chk("reset_rf_data", bus.rf_data, 32'd0);
    chk("reset_ext_ready", 32'(bus.ext_ready), 32'd0);
    chk("reset_stall", 32'(bus.core_stall), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    idle();
    neg();
    chk("post_reset_ready", 32'(bus.ext_ready), 32'd1);
    chk("post_reset_stall", 32'(bus.core_stall), 32'd0);

    // Idle port: pushed result written the following cycle
    cyc();
    ext(5'd5, 32'hDEADBEEF);
    exp_wr(5'd5, 32'hDEADBEEF);
    neg();
    chk("idle_no_same_cycle_write", 32'(bus.rf_we), 32'd0);
    chk("idle_ready", 32'(bus.ext_ready), 32'd1);
    cyc();
    idle();
    neg();
    chk("idle_ready_after", 32'(bus.ext_ready), 32'd1);
    cyc();
    neg();
    chk("idle_drained", 32'(bus.rf_we), 32'd0);

    // Starvation: core wins 4 cycles, 5th cycle forced stall pops the head
    cyc();
    ext(5'd7, 32'h11);
    neg();
    cyc();
    idle();
    core(5'd3, 32'h33);
    bus.core_rs1 = 5'd1;
    bus.core_rs2 = 5'd2;
    for (int k = 0; k < 4; k++) exp_wr(5'd3, 32'h33);
    exp_wr(5'd7, 32'h11);
    exp_wr(5'd3, 32'h33);
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("starve_core_wins", 32'(bus.core_stall), 32'd0);
      cyc();
    end
    neg();
    chk("starve_stall", 32'(bus.core_stall), 32'd1);
    cyc();
    neg();
    chk("starve_resume", 32'(bus.core_stall), 32'd0);
    cyc();
    idle();

    // RAW on rs2
    ext(5'd9, 32'h99);
    neg();
    cyc();
    idle();
    core(5'd4, 32'h44);
    bus.core_rs2 = 5'd9;
    exp_wr(5'd9, 32'h99);
    exp_wr(5'd4, 32'h44);
    neg();
    chk("raw_stall", 32'(bus.core_stall), 32'd1);
    cyc();
    neg();
    chk("raw_release", 32'(bus.core_stall), 32'd0);
    cyc();
    idle();

    // WAW on rd
    ext(5'd9, 32'h98);
    neg();
    cyc();
    idle();
    core(5'd9, 32'h90);
    exp_wr(5'd9, 32'h98);
    exp_wr(5'd9, 32'h90);
    neg();
    chk("waw_stall", 32'(bus.core_stall), 32'd1);
    cyc();
    neg();
    chk("waw_release", 32'(bus.core_stall), 32'd0);
    cyc();
    idle();

    // Full FIFO, push-on-full blocked, x0 push dropped, core x0 frees port
    core(5'd3, 32'h33);
    ext(5'd10, 32'hA0);
    for (int k = 0; k < 4; k++) exp_wr(5'd3, 32'h33);
    exp_wr(5'd10, 32'hA0);
    exp_wr(5'd11, 32'hB1);
    exp_wr(5'd5, 32'h55);
    exp_wr(5'd12, 32'hC2);
    neg();
    chk("full_a_ready", 32'(bus.ext_ready), 32'd1);
    cyc();
    ext(5'd11, 32'hB1);
    neg();
    chk("full_b_ready", 32'(bus.ext_ready), 32'd1);
    cyc();
    ext(5'd12, 32'hC2);
    neg();
    chk("full_c_ready", 32'(bus.ext_ready), 32'd0);
    cyc();
    neg();
    chk("full_d_ready", 32'(bus.ext_ready), 32'd0);
    chk("full_d_stall", 32'(bus.core_stall), 32'd0);
    cyc();
    bus.core_we = 1'b0;
    neg();
    chk("full_pop_ready", 32'(bus.ext_ready), 32'd0);
    cyc();
    neg();
    chk("push_pop_ready", 32'(bus.ext_ready), 32'd1);
    cyc();
    ext(5'd0, 32'hFF);
    core(5'd5, 32'h55);
    neg();
    chk("x0_push_ready", 32'(bus.ext_ready), 32'd1);
    cyc();
    bus.ext_valid = 1'b0;
    core(5'd0, 32'h66);
    neg();
    chk("x0_not_stored", 32'(bus.ext_ready), 32'd1);
    cyc();
    idle();
    neg();
    chk("x0_drained", 32'(bus.rf_we), 32'd0);

    // Wrap and order: pushes 1..6 with idle gaps
    wrap_seq = '{5'd1, 5'd2, 5'd0, 5'd3, 5'd4, 5'd0, 5'd5, 5'd6, 5'd0, 5'd0};
    for (int k = 1; k <= 6; k++) exp_wr(5'(k), 32'h100 + 32'(k));
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (wrap_seq[k] != 5'd0) ext(wrap_seq[k], 32'h100 + 32'(wrap_seq[k]));
      else bus.ext_valid = 1'b0;
      neg();
    end
    cyc();
    idle();
    neg();
    chk("wrap_drained", 32'(bus.rf_we), 32'd0);

    // Reset mid-traffic with two entries buffered
    cyc();
    core(5'd3, 32'h33);
    ext(5'd20, 32'h200);
    exp_wr(5'd3, 32'h33);
    exp_wr(5'd3, 32'h33);
    neg();
    cyc();
    ext(5'd21, 32'h210);
    neg();
    cyc();
    ext(5'd22, 32'h220);
    rst_n = 1'b0;
    #1;
    chk("midreset_rf_we", 32'(bus.rf_we), 32'd0);
    chk("midreset_rf_rd", 32'(bus.rf_rd), 32'd0);
    chk("midreset_rf_data", bus.rf_data, 32'd0);
    chk("midreset_ready", 32'(bus.ext_ready), 32'd0);
    chk("midreset_stall", 32'(bus.core_stall), 32'd0);
    cyc();
    rst_n = 1'b1;
    idle();
    neg();
    chk("after_reset_ready", 32'(bus.ext_ready), 32'd1);
    chk("after_reset_no_write", 32'(bus.rf_we), 32'd0);
    cyc();
    neg();
    chk("after_reset_empty", 32'(bus.rf_we), 32'd0);
    cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
